// File: rtl/stack_upstream_arbiter.sv
// stack_upstream_arbiter: merges NUM_SRC packetised upstream sources onto the
// single PE-to-stack upstream bus. Each source has a FIFO with registered
// ready; packets are arbitrated round-robin at SOP/EOP granularity into a
// registered output stage. Framing errors are flagged per source (sticky).
module stack_upstream_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 64,
    parameter int TYPE_W     = 2,
    parameter int OOB_W      = 16,
    parameter int CNTL_W     = 2
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_SRC-1:0]        src__arb__valid,
    input  logic [NUM_SRC*CNTL_W-1:0] src__arb__cntl,
    output logic [NUM_SRC-1:0]        arb__src__ready,
    input  logic [NUM_SRC*TYPE_W-1:0] src__arb__type,
    input  logic [NUM_SRC*DATA_W-1:0] src__arb__data,
    input  logic [NUM_SRC*OOB_W-1:0]  src__arb__oob_data,
    output logic                      pe__stu__valid,
    output logic [CNTL_W-1:0]         pe__stu__cntl,
    input  logic                      stu__pe__ready,
    output logic [TYPE_W-1:0]         pe__stu__type,
    output logic [DATA_W-1:0]         pe__stu__data,
    output logic [OOB_W-1:0]          pe__stu__oob_data,
    output logic [NUM_SRC-1:0]        arb__cntl__err,
    output logic [NUM_SRC-1:0]        arb__cntl__grant
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW = CNTL_W + TYPE_W + DATA_W + OOB_W;
    // cntl field sits at the top of a stored beat: bit CL is "start", CL+1 is "end"
    localparam int CL = BW - CNTL_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FWD  = 1'b1;

    logic [NUM_SRC-1:0][BW-1:0] w_head;
    logic [NUM_SRC-1:0]         w_empty;
    logic [NUM_SRC-1:0]         w_pop;

    logic [0:0]         r_state, w_state_nxt;
    logic [NUM_SRC-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]      r_gidx, w_gidx_nxt;
    logic [IW-1:0]      r_ptr, w_ptr_nxt;
    logic [IW-1:0]      w_win;
    logic [NUM_SRC-1:0] r_err, w_err_set;
    logic               w_found;
    logic               w_adv;
    logic               w_load;
    logic [BW-1:0]      w_load_beat;
    logic               r_out_valid;
    logic [BW-1:0]      r_out_beat;

    assign w_adv = !r_out_valid || stu__pe__ready;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [BW-1:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_wr_ptr;
        logic [AW-1:0] r_rd_ptr;
        logic [AW:0]   r_count;
        logic [AW:0]   w_count_nxt;
        logic          r_ready;
        logic          w_push;

        assign w_push             = src__arb__valid[g] && r_ready;
        assign w_count_nxt        = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop[g]);
        assign w_empty[g]         = (r_count == '0);
        assign w_head[g]          = r_mem[r_rd_ptr];
        assign arb__src__ready[g] = r_ready;

        // beat storage; contents are don't-care until the pointers say otherwise
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {src__arb__cntl[g*CNTL_W +: CNTL_W],
                                    src__arb__type[g*TYPE_W +: TYPE_W],
                                    src__arb__data[g*DATA_W +: DATA_W],
                                    src__arb__oob_data[g*OOB_W +: OOB_W]};
            end
        end

        // pointers, occupancy, and ready registered from post-update occupancy
        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ready  <= 1'b0;
            end else begin
                if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop[g]) r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= w_count_nxt;
                r_ready <= (w_count_nxt <= (AW+1)'(FIFO_DEPTH - 2));
            end
        end

        a_no_overflow: assert property (@(posedge clk) disable iff (!reset_poweron)
            !(w_push && (r_count == (AW+1)'(FIFO_DEPTH))));
    end

    // packet-level arbitration and forwarding decisions
    always_comb begin
        int unsigned v_idx;
        v_idx       = 0;
        w_found     = 1'b0;
        w_win       = '0;
        w_pop       = '0;
        w_load      = 1'b0;
        w_load_beat = '0;
        w_err_set   = '0;
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;

        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_SRC) v_idx = v_idx - NUM_SRC;
            if (!w_found && !w_empty[IW'(v_idx)]) begin
                w_found = 1'b1;
                w_win   = IW'(v_idx);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (w_head[w_win][CL]) begin
                        if (w_adv) begin
                            w_pop[w_win] = 1'b1;
                            w_load       = 1'b1;
                            w_load_beat  = w_head[w_win];
                            w_ptr_nxt    = w_win;
                            if (w_head[w_win][CL+1]) begin
                                w_grant_nxt = '0;
                            end else begin
                                w_grant_nxt        = '0;
                                w_grant_nxt[w_win] = 1'b1;
                                w_gidx_nxt         = w_win;
                                w_state_nxt        = S_FWD;
                            end
                        end
                    end else begin
                        w_pop[w_win]     = 1'b1;
                        w_err_set[w_win] = 1'b1;
                    end
                end
            end
            S_FWD: begin
                if (!w_empty[r_gidx] && w_adv) begin
                    w_pop[r_gidx] = 1'b1;
                    w_load        = 1'b1;
                    w_load_beat   = w_head[r_gidx];
                    if (w_head[r_gidx][CL]) w_err_set[r_gidx] = 1'b1;
                    if (w_head[r_gidx][CL+1]) begin
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // arbitration state, round-robin pointer and sticky error flags
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= IW'(NUM_SRC - 1);
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    // output register toward the stack bus; holds while stalled
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_load;
            if (w_load) r_out_beat <= w_load_beat;
        end
    end

    assign pe__stu__valid    = r_out_valid;
    assign pe__stu__cntl     = r_out_beat[CL +: CNTL_W];
    assign pe__stu__type     = r_out_beat[DATA_W+OOB_W +: TYPE_W];
    assign pe__stu__data     = r_out_beat[OOB_W +: DATA_W];
    assign pe__stu__oob_data = r_out_beat[OOB_W-1:0];
    assign arb__cntl__err    = r_err;
    assign arb__cntl__grant  = r_grant;

endmodule
